restoring_divider: RTL

Iterative unsigned integer divider producing quotient and remainder of two SIZE-bit operands. It uses radix-2 restoring division and retires one quotient bit per clock behind a start/done handshake. It is the inverse companion to the team's combinational radix-4 multiplier and sits in the same arithmetic datapath. Throughput is traded for area: one subtractor, one counter, no operand-width combinational array.

---
 rtl/restoring_divider.sv | 98 +++++++++
 1 files changed

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - iterative radix-2 restoring unsigned divider, one quotient bit per clock
module restoring_divider #(
    parameter int SIZE = 16
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            iStart,
    input  logic [SIZE-1:0] iDividend,
    input  logic [SIZE-1:0] iDivisor,
    output logic            oBusy,
    output logic            oDone,
    output logic [SIZE-1:0] oQuotient,
    output logic [SIZE-1:0] oRemainder,
    output logic            oDivByZero
);

    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count;
    logic [SIZE-1:0] quo, divisor, rem;
    logic [SIZE:0]   rem_sh, trial;
    logic [SIZE-1:0] quo_step, rem_step;

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (iStart) state_next = (iDivisor == '0) ? DONE : CALC;
            CALC:    if (count == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The stored remainder is always below the divisor, so SIZE bits hold it;
    // only the shifted trial needs the extra bit.
    always_comb begin
        rem_sh = {rem, quo[SIZE-1]};
        trial  = rem_sh - {1'b0, divisor};
        if (!trial[SIZE]) begin
            rem_step = trial[SIZE-1:0];
            quo_step = {quo[SIZE-2:0], 1'b1};
        end else begin
            rem_step = rem_sh[SIZE-1:0];
            quo_step = {quo[SIZE-2:0], 1'b0};
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            quo        <= '0;
            rem        <= '0;
            divisor    <= '0;
            count      <= '0;
            oQuotient  <= '0;
            oRemainder <= '0;
            oDivByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        quo     <= iDividend;
                        divisor <= iDivisor;
                        rem     <= '0;
                        count   <= CW'(SIZE);
                        if (iDivisor == '0) begin
                            oQuotient  <= '1;
                            oRemainder <= iDividend;
                            oDivByZero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    quo   <= quo_step;
                    rem   <= rem_step;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        oQuotient  <= quo_step;
                        oRemainder <= rem_step;
                        oDivByZero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oBusy = (state != IDLE);
    assign oDone = (state == DONE);

endmodule
